// File: rtl/craft_pkg.sv
// Shared CRAFT definitions: round counts, RC LFSR constants and steps,
// the tweak permutation Q and the tweakey stream FSM states.
package craft_pkg;

    localparam int NUM_ROUNDS = 32;

    localparam logic [3:0] RC_A_INIT = 4'h1;
    localparam logic [2:0] RC_B_INIT = 3'h1;
    localparam logic [3:0] A_START   = 4'h8;
    localparam logic [2:0] B_START   = 3'h5;

    // Entry i (nibble i, MSB first) is the source nibble of Q(T) nibble i.
    localparam logic [63:0] Q_PERM = 64'hCAF5_E892_B374_601D;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    function automatic logic [63:0] q_permutation(input logic [63:0] t);
        logic [63:0] q;
        logic [3:0]  p;
        q = '0;
        for (int i = 0; i < 16; i++) begin
            p = Q_PERM[(15 - i) * 4 +: 4];
            q[(15 - i) * 4 +: 4] = t[{~p, 2'b00} +: 4];
        end
        return q;
    endfunction

    function automatic logic [3:0] rc_a_fwd(input logic [3:0] a);
        return {a[1] ^ a[0], a[3:1]};
    endfunction

    function automatic logic [2:0] rc_b_fwd(input logic [2:0] b);
        return {b[1] ^ b[0], b[2:1]};
    endfunction

    function automatic logic [3:0] rc_a_inv(input logic [3:0] a);
        return {a[2:0], a[3] ^ a[0]};
    endfunction

    function automatic logic [2:0] rc_b_inv(input logic [2:0] b);
        return {b[1:0], b[2] ^ b[0]};
    endfunction

endpackage

// File: rtl/craft_rc_lfsr_inv.sv
// CRAFT round-constant LFSR pair stepped backwards, one step per round.
module craft_rc_lfsr_inv
    import craft_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_a,
    input  logic [2:0] load_b,
    input  logic       step,
    output logic [7:0] rc
);

    logic [3:0] a;
    logic [2:0] b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= RC_A_INIT;
            b <= RC_B_INIT;
        end else if (load) begin
            a <= load_a;
            b <= load_b;
        end else if (step) begin
            a <= rc_a_inv(a);
            b <= rc_b_inv(b);
        end
    end

    assign rc = {a, 1'b0, b};

endmodule

// File: rtl/craft_dec_tweakey_stream.sv
// CRAFT decryption tweakey source: streams round tweakeys 31..0 as
// nibbles over valid/ready, with the matching round constant.
module craft_dec_tweakey_stream
    import craft_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key,
    input  logic [63:0]  tweak,
    input  logic         start,
    input  logic         abort,
    output logic         busy,
    output logic [3:0]   out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   nib_idx,
    output logic [4:0]   round_idx,
    output logic [7:0]   rc,
    output logic         last_nib,
    output logic         last_round,
    output logic         done
);

    localparam logic [4:0] LAST_ROUND_IDX = 5'(NUM_ROUNDS - 1);

    state_t       state;
    logic [127:0] key_q;
    logic [63:0]  tweak_q;
    logic [3:0]   nib;
    logic [4:0]   round;

    logic         hs;
    logic         accept;
    logic         step;
    logic [63:0]  half;
    logic [63:0]  term;
    logic [63:0]  tk;

    assign hs     = out_valid & out_ready;
    assign accept = (state == IDLE) & start & ~abort;
    assign step   = hs & ~abort & (&nib) & (round != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_q     <= '0;
            tweak_q   <= '0;
            nib       <= '0;
            round     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            key_q     <= key;
                            tweak_q   <= tweak;
                            round     <= LAST_ROUND_IDX;
                            nib       <= '0;
                            state     <= STREAM;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                        end
                    end
                    STREAM: begin
                        if (hs) begin
                            if (!(&nib)) begin
                                nib <= nib + 4'd1;
                            end else if (round != 5'd0) begin
                                nib   <= '0;
                                round <= round - 5'd1;
                            end else begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                                out_valid <= 1'b0;
                                done      <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    craft_rc_lfsr_inv u_rc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .load_a (A_START),
        .load_b (B_START),
        .step   (step),
        .rc     (rc)
    );

    // Even rounds use K0, odd rounds K1; rounds 2,3 mod 4 use Q(T).
    always_comb begin
        half = round[0] ? key_q[63:0] : key_q[127:64];
        term = round[1] ? q_permutation(tweak_q) : tweak_q;
        tk   = half ^ term;
    end

    assign out        = tk[{~nib, 2'b00} +: 4];
    assign nib_idx    = nib;
    assign round_idx  = round;
    assign last_nib   = &nib;
    assign last_round = (round == 5'd0);

endmodule

// File: tb/tb_craft_dec_tweakey_stream.sv
// Randomized self-checking bench for craft_dec_tweakey_stream against a
// round/nibble level model of the decryption tweakey schedule.
module tb_craft_dec_tweakey_stream;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key = '0;
    logic [63:0]  tweak = '0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         busy;
    logic [3:0]   out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [3:0]   nib_idx;
    logic [4:0]   round_idx;
    logic [7:0]   rc;
    logic         last_nib;
    logic         last_round;
    logic         done;

    int checks = 0;
    int failures = 0;

    craft_dec_tweakey_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .tweak      (tweak),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .nib_idx    (nib_idx),
        .round_idx  (round_idx),
        .rc         (rc),
        .last_nib   (last_nib),
        .last_round (last_round),
        .done       (done)
    );

    always #5 clk = ~clk;

    int perm [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
    logic [7:0] rc_fwd [32];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_nib(input logic [127:0] k,
                                           input logic [63:0] t,
                                           input int r, input int i);
        logic [63:0] h;
        int src;
        h   = (r % 2 == 0) ? k[127:64] : k[63:0];
        src = (r % 4 < 2) ? i : perm[i];
        return h[(15 - i) * 4 +: 4] ^ t[(15 - src) * 4 +: 4];
    endfunction

    // Encrypt-direction constants, computed forward from round 0.
    task automatic build_rc();
        int a;
        int b;
        a = 1;
        b = 1;
        for (int r = 0; r < 32; r++) begin
            rc_fwd[r] = 8'(a * 16 + b);
            a = (((a ^ (a >> 1)) & 1) << 3) | (a >> 1);
            b = (((b ^ (b >> 1)) & 1) << 2) | (b >> 1);
        end
    endtask

    bit           m_active = 0;
    bit           m_done = 0;
    int           m_r = 0;
    int           m_i = 0;
    int           m_hs = 0;
    logic [127:0] m_key = '0;
    logic [63:0]  m_tweak = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 0;
            m_done   = 0;
        end else begin
            chk("busy", busy, m_active);
            chk("out_valid", out_valid, m_active);
            chk("done", done, m_done);
            if (m_active) begin
                chk("out", out, exp_nib(m_key, m_tweak, m_r, m_i));
                chk("nib_idx", nib_idx, m_i);
                chk("round_idx", round_idx, m_r);
                chk("rc", rc, rc_fwd[m_r]);
                chk("last_nib", last_nib, m_i == 15);
                chk("last_round", last_round, m_r == 0);
            end
            m_done = 0;
            if (abort) begin
                m_active = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1;
                    m_key    = key;
                    m_tweak  = tweak;
                    m_r      = 31;
                    m_i      = 0;
                    m_hs     = 0;
                end
            end else if (out_ready) begin
                m_hs++;
                if (m_i < 15) begin
                    m_i++;
                end else if (m_r > 0) begin
                    m_r--;
                    m_i = 0;
                end else begin
                    m_active = 0;
                    m_done   = 1;
                    chk("handshakes", m_hs, 512);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int r, input int n, input bit rnd,
                          input int budget);
        int c;
        c = 0;
        while (!(out_valid && round_idx == 5'(r) && nib_idx == 4'(n))
               && c < budget) begin
            out_ready = rnd ? (($urandom % 4) != 0) : 1'b1;
            tick();
            c++;
        end
        chk("reach_point", c < budget, 1);
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            out_ready = rnd ? (($urandom % 4) != 0) : 1'b1;
            tick();
            c++;
        end
        chk("reach_done", done, 1);
    endtask

    initial begin
        int cnt;
        build_rc();
        chk("rc_fwd0", rc_fwd[0], 8'h11);
        chk("rc_fwd1", rc_fwd[1], 8'h84);
        chk("rc_fwd2", rc_fwd[2], 8'h42);
        chk("rc_fwd31", rc_fwd[31], 8'h85);
        chk("rc_fwd30", rc_fwd[30], 8'h12);
        chk("rc_fwd29", rc_fwd[29], 8'h34);
        chk("model_q", exp_nib(128'h0, 64'h0123456789ABCDEF, 31, 0), 4'hC);
        chk("model_k", exp_nib({64'hFFFFFFFFFFFFFFFF, 64'h0}, 64'h0, 30, 0),
            4'hF);

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_out", out, 0);
        chk("rst_nib", nib_idx, 0);
        chk("rst_round", round_idx, 0);
        chk("rst_rc", rc, 8'h11);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed stream with backpressure and an ignored mid-stream start.
        key       = '0;
        tweak     = 64'h0123456789ABCDEF;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("first_valid", out_valid, 1);
        chk("first_out", out, 4'hC);
        run_to(31, 3, 0, 50);
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (s == 2) begin
                start = 1'b1;
                key   = {4{$urandom}};
                tweak = {2{$urandom}};
            end
            tick();
            start = 1'b0;
            chk("stall_out", out, 4'h5);
            chk("stall_nib", nib_idx, 3);
            chk("stall_rc", rc, 8'h85);
        end
        out_ready = 1'b1;
        tick();
        chk("resume_out", out, 4'hE);
        run_to(29, 10, 0, 100);
        chk("r29_out", out, 4'hA);
        chk("r29_rc", rc, 8'h34);
        wait_done(0, 700);

        // Full-speed run timed from start to done, restart in done cycle.
        tick();
        key   = {64'hFFFFFFFFFFFFFFFF, 64'h0};
        tweak = '0;
        start = 1'b1;
        cnt   = 0;
        do begin
            tick();
            start = 1'b0;
            cnt++;
            if (out_valid && round_idx == 5'd30 && nib_idx == 4'd5)
                chk("r30_out", out, 4'hF);
            if (out_valid && round_idx == 5'd31 && nib_idx == 4'd5)
                chk("r31_out", out, 4'h0);
        end while (!done && cnt < 700);
        chk("done_latency", cnt, 513);
        chk("done_round", round_idx, 0);
        chk("done_rc", rc, 8'h11);
        key   = {4{$urandom}};
        tweak = {2{$urandom}};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_valid", out_valid, 1);
        chk("restart_round", round_idx, 31);
        chk("restart_nib", nib_idx, 0);

        // Random backpressure, then abort with a same-cycle handshake.
        run_to(20, 7, 1, 3000);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("abort_no_done", done, 0);
        end

        // Random key/tweak, random backpressure, full schedule.
        for (int n = 0; n < 2; n++) begin
            key   = {4{$urandom}};
            tweak = {2{$urandom}};
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_done(1, 3000);
            tick();
        end

        // Asynchronous reset mid-stream.
        key   = {4{$urandom}};
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rc", rc, 8'h11);
        chk("arst_round", round_idx, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
